sprite_ram_mc: RTL
==================

// Module: sprite_ram_mc
// PURPOSE
//  Multi-channel sprite line RAM: 16-px-wide 1bpp sprites, NUM_SPR x SPR_H lines, CPU-loaded over an Avalon-MM slave.
//  NUM_CH render channels fetch one 16-bit line per request through a round-robin arbiter on the single RAM read port.
//  Per-channel horizontal flip is applied. Sits between the Avalon bus and the sprite/text renderers.
// PARAMETERS
//  NUM_CH   4   number of read channels (1..8)
//  NUM_SPR  32  sprites stored (power of 2, <=256)
//  SPR_H    16  lines per sprite (power of 2, 2..16)
//  AW       $clog2(NUM_SPR*SPR_H/2)  Avalon word address width (derived, not overridden)
// PORTS
//  CLK            in   1           system clock
//  RESET_N        in   1           asynchronous reset, active low
//  AVL_CS         in   1           slave chip select
//  AVL_READ       in   1           read strobe (qualified by AVL_CS)
//  AVL_WRITE      in   1           write strobe (qualified by AVL_CS)
//  AVL_BYTE_EN    in   4           byte enables for writes
//  AVL_ADDR       in   AW          32-bit word address
//  AVL_WRITEDATA  in   32          write data
//  AVL_READDATA   out  32          read data, fixed read latency 1
//  ch_req         in   NUM_CH      per-channel line request (level, held until granted)
//  ch_index       in   NUM_CH*8    sprite index per channel, channel i at [8i+7:8i]
//  ch_line        in   NUM_CH*4    line number per channel, [4i+3:4i]
//  ch_flip        in   NUM_CH      horizontal mirror per channel
//  ch_gnt         out  NUM_CH      one-hot, combinational: request accepted this cycle
//  ch_valid       out  NUM_CH      one-cycle pulse: ch_data slice valid
//  ch_data        out  NUM_CH*16   line data per channel, [16i+15:16i]; bit 15 = leftmost pixel
// BEHAVIOUR
//  Memory: NUM_SPR*SPR_H/2 words x 32 bits, simple dual port, contents not reset.
//   Word w = {line 2k+1, line 2k}; w = index*SPR_H/2 + line/2; line[0]=0 selects [15:0], 1 selects [31:16].
//  Write: AVL_CS&AVL_WRITE at edge -> bytes with AVL_BYTE_EN[b]=1 updated; others unchanged. Dedicated port, never stalls.
//  Avalon read: AVL_CS&AVL_READ in cycle T -> AVL_READDATA valid from edge T+1, held until next Avalon read.
//   Avalon read owns the read port in cycle T: ch_gnt all 0 that cycle.
//  Read-during-write same word, same edge: read returns OLD contents (both Avalon and channel reads).
//  Arbiter: among ch_req asserted, grant the first at or after pointer rr (wrapping); at most one grant per cycle.
//   After grant to channel g, rr <= (g+1) mod NUM_CH. No grant -> rr unchanged.
//   Requester must hold ch_req, ch_index, ch_line, ch_flip stable until the ch_gnt cycle; sampled in grant cycle.
//  Channel latency: grant in cycle T -> ch_valid[g]=1 for exactly cycle T+1 with ch_data slice g.
//   ch_data slice holds last value between valids; other slices untouched.
//  Flip: ch_flip=1 -> ch_data slice = bit-reverse of stored line (bit 0 <-> bit 15).
//  Range: ch_index >= NUM_SPR or ch_line >= SPR_H -> data 16'h0000, still granted and valid (no hang).
//  Back-to-back: a channel may be granted on consecutive cycles if alone; with all NUM_CH requesting,
//   each is served once every NUM_CH cycles (no starvation).
//  Reset (async assert, sync deassert use): ch_valid=0, ch_data=0, AVL_READDATA=0, rr=0, pending valid dropped;
//   RAM contents preserved. ch_gnt all 0 while RESET_N=0.
// TESTING
//  1 Write 0:CFFCDFFD,1:DEADBEEF,2:FEEDECEB (BE=F); ch0 req idx0 line0..5 -> data DFFD,CFFC,BEEF,DEAD,ECEB,FEED, valid 1 cyc after gnt.
//  2 Write addr1 BE=4'b0010 data 0000_1200 over DEADBEEF; Avalon read addr1 -> READDATA=DEAD12EF next cycle.
//  3 All 4 ch req same cycle from reset -> gnt order 0,1,2,3, then ch2 alone -> gnt 2 (rr=0 after ch3, rr advances to 3).
//  4 ch1 flip=1 idx0 line1 (CFFC) -> ch_data[31:16]=3FF3; idx=200 or line=15 with SPR_H=8 -> 0000 with valid.
//  5 Avalon read concurrent with ch0 req -> no ch_gnt that cycle, ch0 granted next cycle; same-word write+read returns old value.
//  6 Assert RESET_N low in cycle after a grant -> ch_valid stays 0, ch_data=0; after release, re-read returns pre-reset RAM data.

Source files
------------

// File: rtl/sprite_ram_mc.sv
// Multi-channel sprite line RAM: Avalon-MM loaded, NUM_CH round-robin line readers
// sharing one RAM read port, with per-channel horizontal flip and out-of-range blanking.
module sprite_ram_mc #(
    parameter  int NUM_CH  = 4,
    parameter  int NUM_SPR = 32,
    parameter  int SPR_H   = 16,
    localparam int AW      = $clog2(NUM_SPR * SPR_H / 2)
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    input  logic                 AVL_CS,
    input  logic                 AVL_READ,
    input  logic                 AVL_WRITE,
    input  logic [3:0]           AVL_BYTE_EN,
    input  logic [AW-1:0]        AVL_ADDR,
    input  logic [31:0]          AVL_WRITEDATA,
    output logic [31:0]          AVL_READDATA,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH*8-1:0]  ch_index,
    input  logic [NUM_CH*4-1:0]  ch_line,
    input  logic [NUM_CH-1:0]    ch_flip,
    output logic [NUM_CH-1:0]    ch_gnt,
    output logic [NUM_CH-1:0]    ch_valid,
    output logic [NUM_CH*16-1:0] ch_data
);

    localparam int DEPTH = NUM_SPR * SPR_H / 2;
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_rd_word;
    logic [CW-1:0] r_rr;
    logic          r_vld;
    logic [CW-1:0] r_ch;
    logic          r_sel;
    logic          r_flip;
    logic          r_oor;
    logic [15:0]   r_hold [NUM_CH];
    logic          r_avl_pend;
    logic [31:0]   r_avl_hold;

    logic          w_avl_rd;
    logic          w_avl_wr;
    logic          w_gnt_any;
    logic [CW-1:0] w_gnt_idx;
    logic [7:0]    w_sel_idx;
    logic [3:0]    w_sel_line;
    logic          w_sel_flip;
    logic          w_ch_oor;
    logic [AW-1:0] w_ch_addr;
    logic [AW-1:0] w_rd_addr;
    logic          w_rd_en;
    logic [15:0]   w_raw;
    logic [15:0]   w_line;

    assign w_avl_rd = AVL_CS & AVL_READ;
    assign w_avl_wr = AVL_CS & AVL_WRITE;

    // Round-robin search starting at r_rr; an Avalon read or reset suppresses all grants.
    always_comb begin
        int unsigned c;
        c         = 0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            c = (int'(r_rr) + k) % NUM_CH;
            if (!w_gnt_any && ch_req[c]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = CW'(c);
            end
        end
        if (!RESET_N || w_avl_rd) begin
            w_gnt_any = 1'b0;
        end
    end

    always_comb begin
        ch_gnt = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_gnt[i] = w_gnt_any && (w_gnt_idx == CW'(i));
        end
    end

    always_comb begin
        w_sel_idx  = '0;
        w_sel_line = '0;
        w_sel_flip = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_gnt_idx == CW'(i)) begin
                w_sel_idx  = ch_index[8*i +: 8];
                w_sel_line = ch_line[4*i +: 4];
                w_sel_flip = ch_flip[i];
            end
        end
    end

    assign w_ch_oor  = ({24'd0, w_sel_idx} >= 32'(NUM_SPR)) || ({28'd0, w_sel_line} >= 32'(SPR_H));
    assign w_ch_addr = AW'(({24'd0, w_sel_idx} * 32'(SPR_H / 2)) + {29'd0, w_sel_line[3:1]});
    assign w_rd_addr = w_avl_rd ? AVL_ADDR : w_ch_addr;
    assign w_rd_en   = w_avl_rd | w_gnt_any;

    always_ff @(posedge CLK) begin
        if (w_avl_wr) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (AVL_BYTE_EN[b]) begin
                    r_mem[AVL_ADDR][8*b +: 8] <= AVL_WRITEDATA[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_rd_en) begin
            r_rd_word <= r_mem[w_rd_addr];
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rr       <= '0;
            r_vld      <= 1'b0;
            r_ch       <= '0;
            r_sel      <= 1'b0;
            r_flip     <= 1'b0;
            r_oor      <= 1'b0;
            r_avl_pend <= 1'b0;
            r_avl_hold <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            if (w_gnt_any) begin
                r_rr   <= (w_gnt_idx == CW'(NUM_CH - 1)) ? '0 : w_gnt_idx + 1'b1;
                r_ch   <= w_gnt_idx;
                r_sel  <= w_sel_line[0];
                r_flip <= w_sel_flip;
                r_oor  <= w_ch_oor;
            end
            r_vld <= w_gnt_any;
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (r_vld && (r_ch == CW'(i))) begin
                    r_hold[i] <= w_line;
                end
            end
            // The RAM output register is shared, so Avalon data is parked before a channel reuses it.
            r_avl_pend <= w_avl_rd;
            if (r_avl_pend) begin
                r_avl_hold <= r_rd_word;
            end
        end
    end

    assign AVL_READDATA = r_avl_pend ? r_rd_word : r_avl_hold;

    always_comb begin
        w_raw  = r_sel ? r_rd_word[31:16] : r_rd_word[15:0];
        w_line = w_raw;
        if (r_flip) begin
            for (int unsigned b = 0; b < 16; b++) begin
                w_line[b] = w_raw[15-b];
            end
        end
        if (r_oor) begin
            w_line = '0;
        end
    end

    always_comb begin
        ch_valid = '0;
        ch_data  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            ch_valid[i]         = r_vld && (r_ch == CW'(i));
            ch_data[16*i +: 16] = ch_valid[i] ? w_line : r_hold[i];
        end
    end

endmodule
